// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, datapath widths and the FIFO entry layout.
package alu_pkg;

    localparam int unsigned ALU_OP_W  = 3;
    localparam int unsigned ALU_RES_W = 8;

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 3'b000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 3'b001;
    localparam logic [ALU_OP_W-1:0] ALU_MUL  = 3'b010;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 3'b011;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 3'b100;
    localparam logic [ALU_OP_W-1:0] ALU_NAND = 3'b101;
    localparam logic [ALU_OP_W-1:0] ALU_NOR  = 3'b110;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 3'b111;

    typedef struct packed {
        logic [ALU_OP_W-1:0]  code;
        logic [ALU_RES_W-1:0] result;
        logic                 carry;
        logic                 zero;
    } alu_entry_t;

endpackage

// File: rtl/alu_result_fifo_if.sv
// Producer and consumer handshakes around the ALU result FIFO; slave is the FIFO view.
interface alu_result_fifo_if;
    import alu_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [ALU_OP_W-1:0]  in_code;
    logic [ALU_RES_W-1:0] in_result;
    logic                 in_carry;

    logic                 out_valid;
    logic                 out_ready;
    logic [ALU_OP_W-1:0]  out_code;
    logic [ALU_RES_W-1:0] out_result;
    logic                 out_carry;
    logic                 out_zero;

    modport slave (
        input  in_valid, in_code, in_result, in_carry, out_ready,
        output in_ready, out_valid, out_code, out_result, out_carry, out_zero
    );

    modport master (
        output in_valid, in_code, in_result, in_carry, out_ready,
        input  in_ready, out_valid, out_code, out_result, out_carry, out_zero
    );

endinterface

// File: rtl/alu_flag_gen.sv
// Status flags for an ALU result: carry is only meaningful for ADD/SUB, zero tests the full result.
module alu_flag_gen
    import alu_pkg::*;
(
    input  logic [ALU_OP_W-1:0]  code,
    input  logic [ALU_RES_W-1:0] result,
    input  logic                 carry,
    output logic                 carry_c,
    output logic                 zero_c
);

    assign carry_c = carry && ((code == ALU_ADD) || (code == ALU_SUB));
    assign zero_c  = (result == '0);

endmodule

// File: rtl/alu_result_fifo.sv
// Registered result FIFO behind the ALU; head entry and handshakes come straight from flops.
// Optional accepted-push counter enabled by ALU_RESULT_FIFO_STATS_EN.
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_result_fifo_if.slave bus,
    output logic [CNT_W-1:0] count,
    output logic [15:0]      stat_accepted
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    alu_entry_t       mem [DEPTH];
    alu_entry_t       head_q;
    alu_entry_t       head_n;
    alu_entry_t       in_entry_c;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr_n;
    logic [PTR_W-1:0] rd_ptr_n;
    logic [CNT_W-1:0] count_n;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             push_c;
    logic             pop_c;
    logic             carry_c;
    logic             zero_c;

    alu_flag_gen u_flag_gen (
        .code    (bus.in_code),
        .result  (bus.in_result),
        .carry   (bus.in_carry),
        .carry_c (carry_c),
        .zero_c  (zero_c)
    );

    always_comb begin
        in_entry_c.code   = bus.in_code;
        in_entry_c.result = bus.in_result;
        in_entry_c.carry  = carry_c;
        in_entry_c.zero   = zero_c;
    end

    // Next-state: the new head is either the entry being written this cycle or already in storage.
    always_comb begin
        push_c   = bus.in_valid && in_ready_q;
        pop_c    = out_valid_q && bus.out_ready;
        wr_ptr_n = push_c ? wr_ptr + PTR_W'(1) : wr_ptr;
        rd_ptr_n = pop_c  ? rd_ptr + PTR_W'(1) : rd_ptr;
        count_n  = count + CNT_W'(push_c) - CNT_W'(pop_c);
        head_n   = '0;
        if (count_n != '0) begin
            if (push_c && (rd_ptr_n == wr_ptr)) begin
                head_n = in_entry_c;
            end else begin
                head_n = mem[rd_ptr_n];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            head_q      <= '0;
        end else begin
            wr_ptr      <= wr_ptr_n;
            rd_ptr      <= rd_ptr_n;
            count       <= count_n;
            in_ready_q  <= (count_n != CNT_W'(DEPTH));
            out_valid_q <= (count_n != '0);
            head_q      <= head_n;
        end
    end

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= in_entry_c;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_code   = head_q.code;
    assign bus.out_result = head_q.result;
    assign bus.out_carry  = head_q.carry;
    assign bus.out_zero   = head_q.zero;

`ifdef ALU_RESULT_FIFO_STATS_EN
    logic [15:0] stat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= '0;
        end else if (push_c && (stat_q != 16'hFFFF)) begin
            stat_q <= stat_q + 16'd1;
        end
    end

    assign stat_accepted = stat_q;
`else
    assign stat_accepted = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Scoreboard bench for alu_result_fifo: expected entries queued at push, compared at the head each cycle.
module tb_alu_result_fifo;
    import alu_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk;
    logic             rst_n;
    logic [CNT_W-1:0] count;
    logic [15:0]      stat_accepted;

    alu_result_fifo_if bus ();

    alu_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .count         (count),
        .stat_accepted (stat_accepted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks;
    int         n_fail;
    int         n_push;
    alu_entry_t sb_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] c, input logic [7:0] r, input logic cy);
        bus.in_valid  = v;
        bus.in_code   = c;
        bus.in_result = r;
        bus.in_carry  = cy;
    endtask

    // Checks the current head/status against the model, then advances one clock.
    task automatic step();
        alu_entry_t e;
        alu_entry_t h;
        logic       push_m;
        logic       pop_m;
        check("count", 32'(count), 32'(sb_q.size()));
        check("in_ready", 32'(bus.in_ready), 32'(sb_q.size() != DEPTH));
        check("out_valid", 32'(bus.out_valid), 32'(sb_q.size() != 0));
        if (sb_q.size() != 0) begin
            h = sb_q[0];
            check("head_code", 32'(bus.out_code), 32'(h.code));
            check("head_result", 32'(bus.out_result), 32'(h.result));
            check("head_carry", 32'(bus.out_carry), 32'(h.carry));
            check("head_zero", 32'(bus.out_zero), 32'(h.zero));
        end else begin
            check("empty_result", 32'(bus.out_result), 32'd0);
        end
        push_m = bus.in_valid && (sb_q.size() != DEPTH);
        pop_m  = bus.out_ready && (sb_q.size() != 0);
        if (pop_m) void'(sb_q.pop_front());
        if (push_m) begin
            e.code   = bus.in_code;
            e.result = bus.in_result;
            e.carry  = bus.in_carry && (bus.in_code == 3'b000 || bus.in_code == 3'b001);
            e.zero   = (bus.in_result == 8'h00);
            sb_q.push_back(e);
            n_push++;
        end
        @(posedge clk);
        #1;
    endtask

    // Asserts reset between edges, checks the immediate effect, releases between edges.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_stat", 32'(stat_accepted), 32'd0);
        sb_q.delete();
        n_push = 0;
        drive(1'b0, 3'b000, 8'h00, 1'b0);
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("rst_hold_in_ready", 32'(bus.in_ready), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        drive(1'b0, 3'b000, 8'h00, 1'b0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8 && sb_q.size() != 0; i++) step();
        bus.out_ready = 1'b0;
        step();
    endtask

    initial begin
        int exp_stat;
        n_checks = 0;
        n_fail   = 0;
        n_push   = 0;
        rst_n    = 1'b1;
        bus.out_ready = 1'b0;
        drive(1'b0, 3'b000, 8'h00, 1'b0);
        do_reset();

        // ADD with carry, then AND whose carry must be masked and result is zero.
        drive(1'b1, 3'b000, 8'h12, 1'b1);
        step();
        drive(1'b0, 3'b000, 8'h00, 1'b0);
        check("first_valid", 32'(bus.out_valid), 32'd1);
        check("first_result", 32'(bus.out_result), 32'h12);
        step();
        drain();
        drive(1'b1, 3'b011, 8'h00, 1'b1);
        step();
        check("masked_carry", 32'(bus.out_carry), 32'd0);
        check("zero_flag", 32'(bus.out_zero), 32'd1);
        drain();

        // Fill to full with the consumer stalled; extra push must be dropped.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 3'($urandom_range(0, 7)), 8'(i), 1'b1);
            step();
        end
        drive(1'b1, 3'b001, 8'h05, 1'b1);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        check("full_count", 32'(count), 32'd4);
        step();
        step();
        drain();
        check("drained_valid", 32'(bus.out_valid), 32'd0);

        // Steady state at count 2 with concurrent push and pop across pointer wrap.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            step();
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 3'($urandom_range(0, 7)), (i % 3 == 0) ? 8'h00 : 8'($urandom_range(1, 255)),
                  1'($urandom_range(0, 1)));
            step();
            check("steady_count", 32'(count), 32'd2);
        end
        drain();

        // Reset mid-operation with three entries held.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'b010, 8'(8'h40 + i), 1'b0);
            step();
        end
        do_reset();
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("post_rst_valid", 32'(bus.out_valid), 32'd0);
        step();

        // Seven accepted and two refused pushes for the statistics counter.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'b001, 8'(8'h60 + i), 1'b1);
            step();
        end
        drive(1'b1, 3'b001, 8'h70, 1'b1);
        step();
        step();
        drain();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'b111, 8'(8'h80 + i), 1'b0);
            step();
        end
        drain();
`ifdef ALU_RESULT_FIFO_STATS_EN
        exp_stat = 7;
`else
        exp_stat = 0;
`endif
        check("stat_model_pushes", 32'(n_push), 32'd7);
        check("stat_accepted", 32'(stat_accepted), 32'(exp_stat));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
- Registered output stage that sits directly downstream of the 4-bit ALU.
- Captures each ALU result (8-bit result, carry flag, opcode) into a small FIFO through a valid/ready handshake.
- Derives the zero and carry status flags and presents entries in order to the consumer (writeback/display logic).
- Decouples the combinational ALU from a consumer that may stall.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, >= 2.
- CNT_W, 3, width of the occupancy count; must equal log2(DEPTH)+1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream has an ALU result this cycle.
- in_ready  output  1  FIFO can accept; equals !full.
- in_code  input  3  ALU opcode that produced in_result.
- in_result  input  8  ALU result.
- in_carry  input  1  ALU carry flag.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  consumer accepts the head entry.
- out_code  output  3  head opcode.
- out_result  output  8  head result.
- out_carry  output  1  head carry; forced 0 unless opcode is ADD (000) or SUB (001).
- out_zero  output  1  head result == 8'h00.
- count  output  CNT_W  current occupancy, 0..DEPTH.
- stat_accepted  output  16  accepted-push counter (see Optional Feature).

Behaviour:
- Clock and reset
  - Single clock: clk.
  - rst_n is asynchronous, active-low.
  - While rst_n = 0: pointers = 0, count = 0, out_valid = 0, in_ready = 0 (held low during reset), stat_accepted = 0.
  - On the first clk edge after release: in_ready = 1.
  - Storage contents are don't-care after reset. out_* data fields read 0 while empty.
- Handshakes
  - Push occurs when in_valid && in_ready at a rising edge.
  - Pop occurs when out_valid && out_ready at a rising edge.
- Flags and stored values
  - Flags are computed at push time and stored with the entry:
    - zero = (in_result == 0).
    - carry = in_carry && (in_code == 3'b000 || in_code == 3'b001).
  - in_result is stored unmodified, all 8 bits.
- Latency and ordering
  - One cycle from push to visibility: a push into an empty FIFO asserts out_valid on the next cycle.
  - No combinational fall-through.
  - Order is strictly FIFO.
- Handshake signal rules
  - in_ready = (count != DEPTH), from registered state only; no combinational dependence on out_ready.
  - out_valid = (count != 0).
  - out_* is stable while out_valid && !out_ready.
- Boundary conditions
  - Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
  - Full: in_ready = 0. A push attempt is ignored, and upstream must hold its data. A pop in the same cycle frees a slot, but in_ready only rises on the next cycle.
  - Empty: a pop attempt is ignored because out_valid = 0.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - count never exceeds DEPTH and never underflows.
- Reset mid-operation: all entries are discarded immediately (asynchronously) and out_valid drops to 0 without waiting for clk.

Optional Feature:
- Macro: ALU_RESULT_FIFO_STATS_EN.
- Defined:
  - stat_accepted increments by 1 on every push.
  - Saturates at 16'hFFFF.
  - Cleared by rst_n.
- Undefined: stat_accepted is tied to 16'h0000 and no counter flops are synthesized.
- The port list is identical in both builds.

Decomposition:
- Shared package alu_pkg holds:
  - the opcode constants ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_MUL=3'b010, ALU_AND=3'b011, ALU_OR=3'b100, ALU_NAND=3'b101, ALU_NOR=3'b110, ALU_XOR=3'b111;
  - the widths ALU_OP_W=3 and ALU_RES_W=8;
  - a packed entry typedef alu_entry_t {code, result, carry, zero}.
- One natural sub-module: alu_flag_gen, combinational, which takes code, result and carry and produces the masked carry and zero.
- The FIFO storage and pointer logic stay in the top module.

Test Plan:
- Reset then push {code=000, result=8'h12, carry=1} -> out_valid=1 on the following cycle, out_result=8'h12, out_carry=1, out_zero=0, count=1.
- Push {code=011, result=8'h00, carry=1} -> out_carry=0 (masked), out_zero=1.
- Hold out_ready=0 and push 4 entries 8'h01..8'h04 -> in_ready=0 and count=4. A 5th push of 8'h05 is ignored. Then drain with out_ready=1 -> 8'h01, 8'h02, 8'h03, 8'h04 in order, and out_valid=0 after the last.
- Count=2, then push and pop in the same cycle -> count stays 2, popped head correct, new entry appended. Repeat 10 times to cover pointer wrap; no data loss.
- Count=3, assert rst_n=0 between clock edges -> out_valid and count go to 0 immediately. After release, the FIFO is empty and in_ready=1.
- With ALU_RESULT_FIFO_STATS_EN defined, 7 accepted pushes and 2 refused pushes (FIFO full) -> stat_accepted=7. Without the macro -> stat_accepted=0.
